// File: rtl/mem_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared bus widths and master identifiers for the CPU/DMA memory arbiter.
//   ADDR_W : byte address width of every master and of the memory port
//   XLEN   : data word width
//   mst_e  : master id used to tag an outstanding read response
// ----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int XLEN   = 32;

    typedef enum logic {
        MST_CPU = 1'b0,
        MST_DMA = 1'b1
    } mst_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
// Merges the CPU data port and the DMA master port onto one single-port RAM.
// The CPU wins contention unless the DMA has already lost DMA_MAX_WAIT
// consecutive cycles, in which case the DMA is forced through. Read data is
// returned one cycle after the grant, qualified by the owner's rvalid.
//
// Ports
//   clk, rst_n                      : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata/wstrb     : CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid, cpu_rdata  : CPU grant and read return
//   dma_*                           : same set for the DMA master
//   mem_req/we/addr/wdata/wstrb     : memory port, muxed from the winner
//   mem_rdata                       : memory read data, one cycle after read
// ----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DMA_MAX_WAIT = 4,
    parameter int WAIT_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [XLEN-1:0]   cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [XLEN-1:0]   cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [XLEN-1:0]   dma_wdata,
    input  logic [3:0]        dma_wstrb,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [XLEN-1:0]   dma_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [XLEN-1:0]   mem_rdata
);

    logic [WAIT_W-1:0] wait_cnt;
    logic              rsp_pend;
    mst_e              rsp_owner;
    logic              dma_win;

    // DMA wins when alone, or when it has exhausted its wait budget.
    function automatic logic dma_wins(input logic              c_req,
                                      input logic              d_req,
                                      input logic [WAIT_W-1:0] cnt);
        return d_req & (~c_req | (cnt == WAIT_W'(DMA_MAX_WAIT)));
    endfunction

    assign dma_win = dma_wins(cpu_req, dma_req, wait_cnt);

    // Grants are forced low during reset so nothing reaches the RAM.
    assign dma_gnt = rst_n & dma_win;
    assign cpu_gnt = rst_n & cpu_req & ~dma_win;
    assign mem_req = cpu_gnt | dma_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_wstrb = dma_wstrb;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wstrb = cpu_wstrb;
        end
    end

    // A response left over from before reset must never surface, including
    // in the first reset cycle before the pending flag has been cleared.
    assign cpu_rvalid = rst_n & rsp_pend & (rsp_owner == MST_CPU);
    assign dma_rvalid = rst_n & rsp_pend & (rsp_owner == MST_DMA);
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_pend  <= 1'b0;
            rsp_owner <= MST_CPU;
            wait_cnt  <= '0;
        end else begin
            rsp_pend  <= mem_req & ~mem_we;
            rsp_owner <= (dma_gnt & ~dma_we) ? MST_DMA : MST_CPU;
            // Counts consecutive lost cycles only; any gap in dma_req restarts it.
            if (!dma_req || dma_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_W'(DMA_MAX_WAIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int MAXW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [XLEN-1:0]   cpu_wdata, cpu_rdata;
    logic [3:0]        cpu_wstrb;
    logic              dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [ADDR_W-1:0] dma_addr;
    logic [XLEN-1:0]   dma_wdata, dma_rdata;
    logic [3:0]        dma_wstrb;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata, mem_rdata;
    logic [3:0]        mem_wstrb;

    mem_bus_arbiter #(.DMA_MAX_WAIT(MAXW), .WAIT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_wstrb(dma_wstrb), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    // RAM attached to the DUT's memory port
    logic [31:0] init_img [0:1023];
    logic [31:0] ram      [0:1023];
    logic        load;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic int widx(input logic [ADDR_W-1:0] a);
        return int'(a[11:2]);
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_img[i];
        end else if (mem_req) begin
            if (mem_we) ram[widx(mem_addr)] <= merge(ram[widx(mem_addr)], mem_wdata, mem_wstrb);
            else        mem_rdata <= ram[widx(mem_addr)];
        end
    end

    // Reference model state
    logic [31:0] ref_ram [0:1023];
    int          lost;
    bit          pend_v, pend_dma;
    logic [31:0] pend_data;
    bit          e_cpu_gnt, e_dma_gnt;
    int          n_vec, n_err;

    // Observed outputs of the last checked cycle
    logic        obs_cpu_gnt, obs_dma_gnt, obs_cpu_rv, obs_dma_rv, obs_mem_req;
    logic [31:0] obs_cpu_rd, obs_dma_rd, obs_wait;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        if (!rst_n) begin
            e_cpu_gnt = 1'b0;
            e_dma_gnt = 1'b0;
        end else begin
            e_dma_gnt = dma_req && (!cpu_req || lost >= MAXW);
            e_cpu_gnt = cpu_req && !e_dma_gnt;
        end
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu_gnt));
        chk("dma_gnt", 32'(dma_gnt), 32'(e_dma_gnt));
        chk("mem_req", 32'(mem_req), 32'(e_cpu_gnt | e_dma_gnt));
        if (e_dma_gnt) begin
            chk("mem_we_dma",    32'(mem_we),    32'(dma_we));
            chk("mem_addr_dma",  32'(mem_addr),  32'(dma_addr));
            chk("mem_wdata_dma", mem_wdata,      dma_wdata);
            chk("mem_wstrb_dma", 32'(mem_wstrb), 32'(dma_wstrb));
        end else if (e_cpu_gnt) begin
            chk("mem_we_cpu",    32'(mem_we),    32'(cpu_we));
            chk("mem_addr_cpu",  32'(mem_addr),  32'(cpu_addr));
            chk("mem_wdata_cpu", mem_wdata,      cpu_wdata);
            chk("mem_wstrb_cpu", 32'(mem_wstrb), 32'(cpu_wstrb));
        end
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(rst_n && pend_v && !pend_dma));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(rst_n && pend_v && pend_dma));
        if (rst_n && pend_v) begin
            if (pend_dma) chk("dma_rdata", dma_rdata, pend_data);
            else          chk("cpu_rdata", cpu_rdata, pend_data);
        end
        chk("wait_cnt", 32'(dut.wait_cnt), 32'(lost));
        obs_cpu_gnt = cpu_gnt;    obs_dma_gnt = dma_gnt;
        obs_cpu_rv  = cpu_rvalid; obs_dma_rv  = dma_rvalid;
        obs_cpu_rd  = cpu_rdata;  obs_dma_rd  = dma_rdata;
        obs_mem_req = mem_req;    obs_wait    = 32'(dut.wait_cnt);
    endtask

    task automatic update_model();
        if (!rst_n) begin
            lost   = 0;
            pend_v = 1'b0;
            return;
        end
        pend_v = 1'b0;
        if (e_dma_gnt) begin
            if (dma_we) ref_ram[widx(dma_addr)] = merge(ref_ram[widx(dma_addr)], dma_wdata, dma_wstrb);
            else begin pend_v = 1'b1; pend_dma = 1'b1; pend_data = ref_ram[widx(dma_addr)]; end
        end else if (e_cpu_gnt) begin
            if (cpu_we) ref_ram[widx(cpu_addr)] = merge(ref_ram[widx(cpu_addr)], cpu_wdata, cpu_wstrb);
            else begin pend_v = 1'b1; pend_dma = 1'b0; pend_data = ref_ram[widx(cpu_addr)]; end
        end
        if (dma_req && !e_dma_gnt) lost = (lost < MAXW) ? lost + 1 : MAXW;
        else                       lost = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic set_cpu(input bit req, input bit we, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
    endtask

    task automatic set_dma(input bit req, input bit we, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d; dma_wstrb = s;
    endtask

    function automatic logic [15:0] rand_addr();
        return 16'($urandom_range(0, 1023) << 2);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] src_snap [0:63];
    logic [31:0] dbuf;
    int          cnt, i, ph, cycles, cpu_stores;
    bit          granted;
    logic [31:0] cnt_val;

    initial begin
        n_vec = 0; n_err = 0; lost = 0; pend_v = 1'b0; pend_dma = 1'b0; pend_data = '0;
        rst_n = 1'b0; load = 1'b1;
        set_cpu(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        for (int k = 0; k < 1024; k++) init_img[k] = $urandom;
        init_img[16'h200 >> 2] = 32'hA000_0000;
        for (int k = 0; k < 1024; k++) ref_ram[k] = init_img[k];

        // Reset: all grants/valids low even with requests pending
        tick(); tick();
        load = 1'b0;
        set_cpu(1, 0, 16'h200, 0, 0);
        set_dma(1, 0, 16'h204, 0, 0);
        tick();
        chk("rst_mem_req", 32'(obs_mem_req), 0);
        set_cpu(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // CPU-only read of 0x200
        set_cpu(1, 0, 16'h200, 0, 0);
        tick();
        chk("rd200_gnt", 32'(obs_cpu_gnt), 1);
        set_cpu(0, 0, 0, 0, 0);
        tick();
        chk("rd200_rvalid", 32'(obs_cpu_rv), 1);
        chk("rd200_data", obs_cpu_rd, 32'hA000_0000);
        chk("rd200_dma_rv", 32'(obs_dma_rv), 0);

        // Simultaneous reads: CPU first, DMA next cycle
        set_cpu(1, 0, 16'h500, 0, 0);
        set_dma(1, 0, 16'h204, 0, 0);
        tick();
        chk("both_cpu_gnt", 32'(obs_cpu_gnt), 1);
        chk("both_dma_wait", 32'(obs_dma_gnt), 0);
        set_cpu(0, 0, 0, 0, 0);
        tick();
        chk("both_dma_gnt", 32'(obs_dma_gnt), 1);
        chk("both_cpu_rv", 32'(obs_cpu_rv), 1);
        chk("both_cpu_rd", obs_cpu_rd, init_img[16'h500 >> 2]);
        set_dma(0, 0, 0, 0, 0);
        tick();
        chk("both_dma_rv", 32'(obs_dma_rv), 1);
        chk("both_dma_rd", obs_dma_rd, init_img[16'h204 >> 2]);

        // DMA starvation bound under continuous CPU stores
        set_dma(1, 0, 16'h208, 0, 0);
        cnt = 0; granted = 1'b0;
        for (int k = 0; k < 12 && !granted; k++) begin
            set_cpu(1, 1, 16'h500, $urandom, 4'hF);
            tick();
            if (obs_dma_gnt) granted = 1'b1;
            else             cnt++;
        end
        chk("starve_granted", 32'(granted), 1);
        chk("starve_lost", 32'(cnt), MAXW);
        chk("starve_wcnt_at_gnt", obs_wait, MAXW);
        set_dma(1, 0, 16'h20C, 0, 0);
        set_cpu(1, 1, 16'h500, $urandom, 4'hF);
        tick();
        chk("post_force_cpu_wins", 32'(obs_cpu_gnt), 1);
        chk("post_force_wcnt", obs_wait, 0);
        set_cpu(0, 0, 0, 0, 0);
        tick();
        set_dma(0, 0, 0, 0, 0);
        tick();

        // DMA write then CPU read-back
        set_dma(1, 1, 16'h300, 32'h1234_5678, 4'hF);
        tick();
        chk("dwr_gnt", 32'(obs_dma_gnt), 1);
        set_dma(0, 0, 0, 0, 0);
        set_cpu(1, 0, 16'h300, 0, 0);
        tick();
        chk("dwr_no_rv", 32'(obs_dma_rv), 0);
        set_cpu(0, 0, 0, 0, 0);
        tick();
        chk("dwr_read_rv", 32'(obs_cpu_rv), 1);
        chk("dwr_read_data", obs_cpu_rd, 32'h1234_5678);

        // Reset right after a granted CPU read drops the response
        set_cpu(1, 0, 16'h200, 0, 0);
        tick();
        set_cpu(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_no_rv", 32'(obs_cpu_rv), 0);
        set_cpu(1, 0, 16'h204, 0, 0);
        tick();
        chk("rst_mid_no_gnt", 32'(obs_cpu_gnt), 0);
        chk("rst_mid_no_rv2", 32'(obs_cpu_rv), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_resume_gnt", 32'(obs_cpu_gnt), 1);
        set_cpu(0, 0, 0, 0, 0);
        tick();
        chk("rst_resume_rv", 32'(obs_cpu_rv), 1);

        // Random mixed traffic, requests held until granted
        for (int c = 0; c < 400; c++) begin
            if (!cpu_req || e_cpu_gnt) begin
                if ($urandom_range(0, 2) != 0)
                    set_cpu(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(1, 15)));
                else
                    set_cpu(0, 0, 0, 0, 0);
            end
            if (!dma_req || e_dma_gnt) begin
                if ($urandom_range(0, 2) != 0)
                    set_dma(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(1, 15)));
                else
                    set_dma(0, 0, 0, 0, 0);
            end
            tick();
        end
        set_cpu(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        tick();

        // 64-word DMA copy 0x200 -> 0x300 with CPU counter stores to 0x500
        for (int k = 0; k < 64; k++) src_snap[k] = ref_ram[(16'h200 >> 2) + k];
        i = 0; ph = 0; cycles = 0; cpu_stores = 0; cnt_val = 32'd1; dbuf = '0;
        while (i < 64 && cycles < 3000) begin
            case (ph)
                0:       set_dma(1, 0, 16'h200 + 16'(i * 4), 0, 0);
                1:       set_dma(0, 0, 0, 0, 0);
                default: set_dma(1, 1, 16'h300 + 16'(i * 4), dbuf, 4'hF);
            endcase
            if (!cpu_req || e_cpu_gnt) begin
                if ($urandom_range(0, 2) != 0) set_cpu(1, 1, 16'h500, cnt_val, 4'hF);
                else                           set_cpu(0, 0, 0, 0, 0);
            end
            tick();
            cycles++;
            if (e_cpu_gnt) begin
                cnt_val++;
                cpu_stores++;
                set_cpu(1, 1, 16'h500, cnt_val, 4'hF);
                if ($urandom_range(0, 2) == 0) set_cpu(0, 0, 0, 0, 0);
            end
            case (ph)
                0: if (e_dma_gnt) ph = 1;
                1: if (obs_dma_rv) begin dbuf = obs_dma_rd; ph = 2; end
                default: if (e_dma_gnt) begin i++; ph = 0; end
            endcase
        end
        set_cpu(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        tick(); tick();
        chk("copy_done", 32'(i), 64);
        for (int k = 0; k < 64; k++) chk("copy_dst", ram[(16'h300 >> 2) + k], src_snap[k]);
        chk("cpu_progress", 32'(cpu_stores > 0), 1);
        chk("cpu_counter", ram[16'h500 >> 2], cnt_val - 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
